// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults for the serial word transmitter and its receive register
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} tx_state_t;
  localparam int DEFAULT_DATA_LENGTH = 4;
endpackage

// File: rtl/serial_word_tx_piso_shift.sv
// piso_shift: load/shift-right register whose LSB is the serial output
module piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         sout
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    if (reset) r_q <= '0;
    else if (load) r_q <= d;
    else if (shift) r_q <= {1'b0, r_q[W-1:1]};
  assign sout = r_q[0];
endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: valid/ready word input, LSB-first serial output with optional even parity
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter bit PARITY_EN   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   sout,
  output logic                   sout_en,
  output logic                   done,
  output logic                   busy
);
  localparam int CW = $clog2(DATA_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH - 1);
  tx_state_t r_state, w_next;
  logic [CW-1:0] r_bitcnt;
  logic r_par, w_accept, w_last, w_q0;
  assign din_ready = (r_state == IDLE) && !reset;
  assign w_accept  = din_valid && din_ready;
  assign w_last    = r_bitcnt == LAST;
  always_comb
    w_next = r_state == IDLE  ? (w_accept ? SHIFT : IDLE) :
             r_state == SHIFT ? (w_last ? (PARITY_EN ? PARITY : DONE) : SHIFT) :
             r_state == PARITY ? DONE : IDLE;
  // the counter holds at LAST so it never wraps for power-of-two widths
  always_ff @(posedge clk)
    if (reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_bitcnt <= w_accept ? '0 : (r_state == SHIFT && !w_last) ? r_bitcnt + 1'b1 : r_bitcnt;
      r_par    <= w_accept ? ^din : r_par;
    end
  piso_shift #(.W(DATA_LENGTH)) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (w_accept),
    .shift(r_state == SHIFT),
    .d    (din),
    .sout (w_q0)
  );
  assign sout    = r_state == SHIFT ? w_q0 : r_state == PARITY ? r_par : 1'b0;
  assign sout_en = r_state == SHIFT || r_state == PARITY;
  assign done    = r_state == DONE;
  assign busy    = r_state != IDLE;
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed frames on a plain and a parity instance, scoreboarded serial bits
module tb_serial_word_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] din [2];
  logic valid [2];
  logic rdy [2], sout [2], sout_en [2], done [2], busy [2];
  logic [3:0] rx [2];
  bit q0 [$], q1 [$];
  int acc [$];
  int cyc = 0, checks = 0, failures = 0, done_cnt0 = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.DATA_LENGTH(4), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din[0]), .din_valid(valid[0]), .din_ready(rdy[0]),
    .sout(sout[0]), .sout_en(sout_en[0]), .done(done[0]), .busy(busy[0]));
  serial_word_tx #(.DATA_LENGTH(4), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .din(din[1]), .din_valid(valid[1]), .din_ready(rdy[1]),
    .sout(sout[1]), .sout_en(sout_en[1]), .done(done[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // serial-in receive register: inserts at MSB, shifts right on each enabled bit
  always @(posedge clk) begin
    if (!reset && rdy[0] && valid[0]) acc.push_back(cyc);
    cyc = cyc + 1;
    if (reset) begin
      rx[0] <= '0;
      rx[1] <= '0;
    end else begin
      if (sout_en[0]) rx[0] <= {sout[0], rx[0][3:1]};
      if (sout_en[1]) rx[1] <= {sout[1], rx[1][3:1]};
    end
  end

  always @(negedge clk) begin
    if (done[0]) done_cnt0++;
    if (sout_en[0]) chk("bit_u0", sout[0], q0.size() != 0 ? q0.pop_front() : 1'bx);
    else chk("idle_sout_u0", sout[0], 0);
    if (sout_en[1]) chk("bit_u1", sout[1], q1.size() != 0 ? q1.pop_front() : 1'bx);
    else chk("idle_sout_u1", sout[1], 0);
  end

  task automatic send(input bit p, input logic [3:0] w);
    int n = p ? 5 : 4;
    @(negedge clk);
    chk("ready_before", rdy[p], 1);
    for (int i = 0; i < 4; i++) if (p) q1.push_back(w[i]); else q0.push_back(w[i]);
    if (p) q1.push_back(^w);
    din[p] = w;
    valid[p] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[p] = 1'b0;
    din[p] = ~w;
    chk("busy_first", busy[p], 1);
    chk("ready_busy", rdy[p], 0);
    repeat (n - 1) @(negedge clk);
    chk("no_early_done", done[p], 0);
    @(negedge clk);
    chk("done_pulse", done[p], 1);
    chk("rx_word", rx[p], p ? {^w, w[3:1]} : w);
    @(negedge clk);
    chk("ready_after", rdy[p], 1);
    chk("done_low", done[p], 0);
    chk("queue_drained", p ? q1.size() : q0.size(), 0);
  endtask

  initial begin
    int dc;
    din[0] = '0; din[1] = '0; valid[0] = 1'b0; valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sout", sout[0], 0);
    chk("rst_sout_en", sout_en[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_busy", busy[1], 0);
    chk("rst_ready_gated", rdy[0], 0);
    reset = 1'b0;
    #1 chk("rst_ready_release", rdy[0], 1);
    send(0, 4'b1011);
    send(1, 4'b0111);
    send(1, 4'b0110);
    // back-to-back: valid held high, din disturbed mid-frame
    @(negedge clk);
    acc.delete();
    for (int i = 0; i < 4; i++) q0.push_back(i[0] ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) q0.push_back(i[0] ? 1'b0 : 1'b1);
    din[0] = 4'hA;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    din[0] = 4'hF;
    @(negedge clk);
    din[0] = 4'h5;
    repeat (3) @(negedge clk);
    chk("b2b_ready", rdy[0], 1);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    din[0] = 4'h0;
    repeat (4) @(negedge clk);
    chk("b2b_done", done[0], 1);
    chk("b2b_rx", rx[0], 4'h5);
    @(negedge clk);
    chk("b2b_ready_after", rdy[0], 1);
    chk("b2b_accepts", acc.size(), 2);
    chk("b2b_gap", acc.size() == 2 ? acc[1] - acc[0] : -1, 6);
    chk("b2b_drained", q0.size(), 0);
    // reset in the second SHIFT cycle
    @(negedge clk);
    q0.push_back(1'b1);
    q0.push_back(1'b0);
    din[0] = 4'b1001;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    dc = done_cnt0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sout_en", sout_en[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_ready_gated", rdy[0], 0);
    reset = 1'b0;
    #1 chk("abort_ready", rdy[0], 1);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt0, dc);
    chk("abort_drained", q0.size(), 0);
    send(0, 4'b1101);
    send(1, 4'b1101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial word transmitter with a valid/ready input handshake. It accepts a DATA_LENGTH-bit word and shifts it out LSB-first, one bit per clock, optionally followed by an even-parity bit. `sout_en` marks each valid bit. The block is the transmitting end for the team's serial-in shift register, which inserts at the MSB and shifts right. After DATA_LENGTH enabled shifts, that register holds the original word.

## Interface
- DATA_LENGTH, 4, word width in bits; legal values are 2 and above.
- PARITY_EN, 0, set to 1 to append one even-parity bit after the data bits.

- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, synchronous, active-high.
- din  in  DATA_LENGTH  parallel word; sampled only on an accept.
- din_valid  in  1  producer has a word on `din`.
- din_ready  out  1  block can accept a word.
- sout  out  1  serial data bit.
- sout_en  out  1  `sout` carries a valid frame bit this cycle.
- done  out  1  one-cycle pulse after the last frame bit.
- busy  out  1  a frame is in progress (state is not IDLE).

## Operation
- The FSM has four states: IDLE, SHIFT, PARITY and DONE.
- **IDLE**
  - `din_ready` = 1.
  - An accept happens when `din_valid` and `din_ready` are both high at a rising edge.
  - On accept: `shreg` <= `din`, `bitcnt` <= 0, `par` <= ^`din`, and the state goes to SHIFT.
- **SHIFT**
  - `sout` = `shreg[0]` and `sout_en` = 1.
  - Each cycle: `shreg` <= {1'b0, `shreg[DATA_LENGTH-1:1]`} and `bitcnt` increments.
  - When `bitcnt` == DATA_LENGTH-1, the next state is PARITY if PARITY_EN is 1, otherwise DONE.
- **PARITY** (only reachable when PARITY_EN = 1)
  - `sout` = `par` and `sout_en` = 1.
  - Next state is DONE.
- **DONE**
  - `done` = 1, `sout_en` = 0, `sout` = 0.
  - Next state is IDLE.
- `sout` is 0 whenever `sout_en` = 0.
- `din_ready` is 0 in every state except IDLE.
  - `din_valid` outside IDLE is ignored.
  - Changes on `din` outside IDLE are ignored; the word is captured only at accept.
- **Even parity:** the data bits plus the parity bit together contain an even number of 1s.
- **Widths**
  - `bitcnt` is $clog2(DATA_LENGTH) bits wide.
  - The counter never wraps during a frame.
  - `shreg` is exactly DATA_LENGTH bits wide.

## Timing
- **Reset values** (from the cycle after `reset` is sampled high):
  - state = IDLE; `shreg`, `bitcnt` and `par` = 0.
  - `sout` = 0, `sout_en` = 0, `done` = 0, `busy` = 0.
  - `din_ready` = 1 once `reset` is low; `din_ready` is forced to 0 in any cycle where `reset` is high.
- **Frame timing**, with an accept at edge k and N = DATA_LENGTH + PARITY_EN:
  - `sout_en` is high in cycles k+1 through k+N.
  - Data bit i appears in cycle k+1+i.
  - `done` is high in cycle k+N+1.
  - `din_ready` returns high in cycle k+N+2.
- **Throughput:** with `din_valid` held high, consecutive accepts are N+2 cycles apart.
- All outputs are decoded from registered state and data only. There is no combinational path from inputs to outputs, except `din_ready` gated by `reset`.
- **Reset mid-frame:** the frame is aborted at that edge. No `done` is produced, and `sout_en` is 0 from the next cycle.
- **Reset coinciding with an accept:** reset wins and no word is captured.

## Structure
- Shared package `serial_pkg` holds:
  - the `tx_state_t` enum (IDLE, SHIFT, PARITY, DONE);
  - the default DATA_LENGTH constant (4), shared with the serial-in receive register.
- There is one natural sub-module, `piso_shift`: a DATA_LENGTH-bit load/shift-right register with `load`, `shift` and `sout` = `q[0]`.
  - It is instantiated by the FSM top.
  - Parity and counter logic stay in the top.

## Test plan
- **Basic frame:** PARITY_EN=0, accept `din`=4'b1011 at edge k.
  - Required: `sout` = 1,1,0,1 in cycles k+1..k+4, with `sout_en` high.
  - Required: `done` pulses in cycle k+5, `din_ready` = 1 in cycle k+6.
- **Parity frame:** PARITY_EN=1, `din`=4'b0111.
  - Required: `sout` = 1,1,1,0, then parity bit 1.
  - Required: `done` at k+6.
- **Parity, even weight:** PARITY_EN=1, `din`=4'b0110. Required: parity bit = 0.
- **Back-to-back:** `din_valid` held high with words 4'hA then 4'h5.
  - Required: accepts 6 cycles apart.
  - Required: serial streams 0,1,0,1 and 1,0,1,0.
  - Required: `din` changes during SHIFT have no effect.
- **Reset mid-frame:** reset asserted in the second SHIFT cycle.
  - Required: from the next cycle, `sout_en`=0, `busy`=0, `done` never pulses.
  - Required: `din_ready`=1 after reset is released.
  - Required: the next word transmits correctly.
- **Loopback:** `sout` and `sout_en` drive the team's 4-bit serial-in register (shift on `sout_en`). For `din`=4'b1101, the register holds 4'b1101 in the cycle `done` is high.
